// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo
//   Single-clock FIFO used as the TX/RX data buffer of the UART core.
//   Each entry is stored with one even-parity bit, and the bit is checked on read.
//   The block also provides programmable almost-full/almost-empty thresholds,
//   an occupancy count, a synchronous flush, and sticky overflow/underflow flags.
//
//   Build option: define UART_FIFO_FWFT_EN for first-word fall-through reads
//   (head entry shown combinationally, 0-latency pop). Leave it undefined for a
//   registered read with 1-cycle latency.
//
// Ports
//   clk_i, rstn_i      clock (rising edge), asynchronous active-low reset
//   flush_i            synchronous flush; empties the FIFO and keeps the sticky flags
//   clr_err_i          clears overflow_o/underflow_o (a new error in the same cycle wins)
//   wr_en_i/wr_data_i  write request and data
//   wr_par_inv_i       inverts the stored parity bit of this write (error injection)
//   rd_en_i            read request / pop
//   rd_data_o          read data
//   rd_valid_o         rd_data_o valid
//   parity_err_o       parity mismatch on rd_data_o
//   full_o, empty_o    count == FIFO_DEPTH / count == 0
//   afull_o, aempty_o  count >= AFULL_THRESH / count <= AEMPTY_THRESH
//   count_o            current occupancy
//   overflow_o         sticky: write attempted while full
//   underflow_o        sticky: read attempted while empty
module uart_sync_fifo #(
    parameter int unsigned FIFO_DEPTH         = 8,
    parameter int unsigned FIFO_WIDTH         = 8,
    parameter int unsigned FIFO_PARITY_ENABLE = 1,
    parameter int unsigned AFULL_THRESH       = 6,
    parameter int unsigned AEMPTY_THRESH      = 2
) (
    input  logic                               clk_i,
    input  logic                               rstn_i,
    input  logic                               flush_i,
    input  logic                               clr_err_i,
    input  logic                               wr_en_i,
    input  logic [FIFO_WIDTH-1:0]              wr_data_i,
    input  logic                               wr_par_inv_i,
    input  logic                               rd_en_i,
    output logic [FIFO_WIDTH-1:0]              rd_data_o,
    output logic                               rd_valid_o,
    output logic                               parity_err_o,
    output logic                               full_o,
    output logic                               empty_o,
    output logic                               afull_o,
    output logic                               aempty_o,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    count_o,
    output logic                               overflow_o,
    output logic                               underflow_o
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

    // Entry layout: {parity bit, data}
    logic [FIFO_WIDTH:0] mem_q [FIFO_DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             afull_q, afull_d;
    logic             aempty_q, aempty_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;

    logic             wr_acc, rd_acc;
    logic             wr_par;
    logic [FIFO_WIDTH:0] head;
    logic             head_err;

    // Flush masks both requests and any error they would otherwise flag.
    assign wr_acc = wr_en_i && !full_q  && !flush_i;
    assign rd_acc = rd_en_i && !empty_q && !flush_i;

    assign wr_par   = (FIFO_PARITY_ENABLE != 0) ? (^wr_data_i ^ wr_par_inv_i) : 1'b0;
    assign head     = mem_q[rd_ptr_q];
    // XOR over data and stored bit together: non-zero means the parity does not match.
    assign head_err = (FIFO_PARITY_ENABLE != 0) && (^head);

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        if (clr_err_i) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end

        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_en_i && full_q) begin
                overflow_d = 1'b1;
            end
            if (rd_en_i && empty_q) begin
                underflow_d = 1'b1;
            end
            if (wr_acc) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (rd_acc) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (wr_acc && !rd_acc) begin
                count_d = count_q + CNT_W'(1);
            end else if (rd_acc && !wr_acc) begin
                count_d = count_q - CNT_W'(1);
            end
        end

        // The flags are registered from count_d, so they change in the same cycle as count_o.
        full_d   = (count_d == CNT_W'(FIFO_DEPTH));
        empty_d  = (count_d == '0);
        afull_d  = (count_d >= CNT_W'(AFULL_THRESH));
        aempty_d = (count_d <= CNT_W'(AEMPTY_THRESH));
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            afull_q     <= 1'b0;
            aempty_q    <= 1'b1;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            full_q      <= full_d;
            empty_q     <= empty_d;
            afull_q     <= afull_d;
            aempty_q    <= aempty_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage has no reset; contents are only ever visible through valid pointers.
    always_ff @(posedge clk_i) begin
        if (wr_acc) begin
            mem_q[wr_ptr_q] <= {wr_par, wr_data_i};
        end
    end

`ifdef UART_FIFO_FWFT_EN
    assign rd_valid_o   = !empty_q;
    assign rd_data_o    = empty_q ? '0 : head[FIFO_WIDTH-1:0];
    assign parity_err_o = !empty_q && head_err;
`else
    logic [FIFO_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  rd_valid_q, rd_valid_d;
    logic                  parity_err_q, parity_err_d;

    always_comb begin
        rd_data_d    = rd_data_q;
        parity_err_d = parity_err_q;
        rd_valid_d   = rd_acc;
        if (rd_acc) begin
            rd_data_d    = head[FIFO_WIDTH-1:0];
            parity_err_d = head_err;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            rd_data_q    <= '0;
            rd_valid_q   <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            rd_data_q    <= rd_data_d;
            rd_valid_q   <= rd_valid_d;
            parity_err_q <= parity_err_d;
        end
    end

    assign rd_valid_o   = rd_valid_q;
    assign rd_data_o    = rd_data_q;
    assign parity_err_o = parity_err_q;
`endif

    assign full_o      = full_q;
    assign empty_o     = empty_q;
    assign afull_o     = afull_q;
    assign aempty_o    = aempty_q;
    assign count_o     = count_q;
    assign overflow_o  = overflow_q;
    assign underflow_o = underflow_q;

endmodule
